mem_access_unit: RTL and testbench

MEM-stage initiator that issues load/store requests to the data memory over a valid/ready request channel plus a read-return channel.
- Generates word-aligned address, byte enables and lane-shifted write data for all MIPS load/store ops, including LWL/LWR/SWL/SWR.
- Extracts and sign/zero-extends or merges load data.
- Stalls the pipeline until the access completes; single outstanding access, little-endian.

---
 rtl/mem_pkg.sv | 29 ++
 rtl/mem_lane_align.sv | 91 +++++++++
 rtl/mem_access_unit.sv | 165 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and op classification for the MEM-stage access unit.
package mem_pkg;

  typedef enum logic [3:0] {
    LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW, SWL, SWR
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DONE
  } state_t;

  function automatic logic is_load(mem_op_t op);
    return op inside {LB, LBU, LH, LHU, LW, LWL, LWR};
  endfunction

  function automatic logic is_store(mem_op_t op);
    return op inside {SB, SH, SW, SWL, SWR};
  endfunction

  // Unaligned-word ops (LWL/LWR/SWL/SWR) and byte ops can never fault.
  function automatic logic misaligned(mem_op_t op, logic [1:0] k);
    case (op)
      LH, LHU, SH: return k[0];
      LW, SW:      return |k;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store data shift, load extract/merge.
// Zero latency; no flow control of its own.
module mem_lane_align
  import mem_pkg::*;
(
  input  mem_op_t     op,
  input  logic [1:0]  k,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_old,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_val
);

  logic [4:0]  sh;
  logic [4:0]  rsh;
  logic [5:0]  keep_sh;
  logic [3:0]  left_mask;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] byte_w;

  always_comb begin
    sh        = {k, 3'b000};
    rsh       = {~k, 3'b000};
    keep_sh   = 6'(sh) + 6'd8;
    left_mask = 4'b1111 >> (2'd3 - k);
    byte_w    = rdata >> sh;
    byte_v    = byte_w[7:0];
    half_v    = k[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be       = 4'b0000;
    wdata    = 32'h0;
    load_val = 32'h0;
    case (op)
      LB: begin
        be       = 4'b0001 << k;
        load_val = {{24{byte_v[7]}}, byte_v};
      end
      LBU: begin
        be       = 4'b0001 << k;
        load_val = {24'h0, byte_v};
      end
      LH: begin
        be       = k[1] ? 4'b1100 : 4'b0011;
        load_val = {{16{half_v[15]}}, half_v};
      end
      LHU: begin
        be       = k[1] ? 4'b1100 : 4'b0011;
        load_val = {16'h0, half_v};
      end
      LW: begin
        be       = 4'b1111;
        load_val = rdata;
      end
      LWL: begin
        be       = left_mask;
        load_val = (rdata << rsh) | (rt_old & (32'hFFFF_FFFF >> keep_sh));
      end
      LWR: begin
        be       = 4'b1111 << k;
        load_val = (rdata >> sh) | (rt_old & ~(32'hFFFF_FFFF >> sh));
      end
      SB: begin
        be    = 4'b0001 << k;
        wdata = {4{store_data[7:0]}};
      end
      SH: begin
        be    = k[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      SW: begin
        be    = 4'b1111;
        wdata = store_data;
      end
      SWL: begin
        be    = left_mask;
        wdata = store_data >> rsh;
      end
      SWR: begin
        be    = 4'b1111 << k;
        wdata = store_data << sh;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator, single outstanding access, little-endian.
// Min latency store 3 / load 4 cycles; stall held until mem_ready/mem_rvalid or timeout.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  mem_op_t     op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] rt_old,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        addr_err,
  output logic        bus_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  mem_op_t       op_q;
  logic [1:0]    k_q;
  logic [31:0]   rt_q;
  logic          err_q;

  mem_op_t       op_sel;
  logic [1:0]    k_sel;
  logic [3:0]    be_c;
  logic [31:0]   wdata_c;
  logic [31:0]   load_c;
  logic          mis;
  logic          accept;
  logic          tmo;

  always_comb begin
    mis    = misaligned(op, addr[1:0]);
    accept = op_valid && !mis;
    tmo    = (cnt == LAST);
    // Live op drives the store lanes in IDLE; the latched op drives load extraction.
    op_sel = (state == IDLE) ? op : op_q;
    k_sel  = (state == IDLE) ? addr[1:0] : k_q;
  end

  mem_lane_align u_align (
    .op         (op_sel),
    .k          (k_sel),
    .store_data (store_data),
    .rdata      (mem_rdata),
    .rt_old     (rt_q),
    .be         (be_c),
    .wdata      (wdata_c),
    .load_val   (load_c)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  // A handshake arriving on the last allowed cycle still wins over the timeout.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = REQ;
      REQ: begin
        if (mem_ready)  state_nx = is_load(op_q) ? WAIT : DONE;
        else if (tmo)   state_nx = DONE;
      end
      WAIT: begin
        if (mem_rvalid) state_nx = DONE;
        else if (tmo)   state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    stall    = 1'b0;
    done     = 1'b0;
    addr_err = 1'b0;
    bus_err  = 1'b0;
    mem_req  = 1'b0;
    case (state)
      IDLE: begin
        stall    = reset && accept;
        addr_err = reset && op_valid && mis;
      end
      REQ: begin
        stall   = 1'b1;
        mem_req = 1'b1;
      end
      WAIT: stall = 1'b1;
      DONE: begin
        done    = 1'b1;
        bus_err = err_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      op_q      <= LB;
      k_q       <= 2'b00;
      rt_q      <= 32'h0;
      err_q     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'b0000;
      mem_wdata <= 32'h0;
      load_data <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            cnt       <= '0;
            err_q     <= 1'b0;
            op_q      <= op;
            k_q       <= addr[1:0];
            rt_q      <= rt_old;
            mem_we    <= is_store(op);
            mem_addr  <= {addr[31:2], 2'b00};
            mem_be    <= be_c;
            mem_wdata <= is_store(op) ? wdata_c : 32'h0;
          end
        end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (!mem_ready && tmo) begin
            err_q     <= 1'b1;
            load_data <= 32'h0;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (mem_rvalid) begin
            load_data <= load_c;
          end else if (tmo) begin
            err_q     <= 1'b1;
            load_data <= 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a byte-level memory model.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        op_valid;
  mem_op_t     op;
  logic [31:0] addr, store_data, rt_old;
  logic        stall, done, addr_err, bus_err;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] c_addr, c_wdata, c_load;
  logic [3:0]  c_be;
  logic        c_we, c_buserr;
  int          c_done_idx, c_stall, c_req, c_hang;

  logic [31:0] mem_model [4];

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op         (op),
    .addr       (addr),
    .store_data (store_data),
    .rt_old     (rt_old),
    .stall      (stall),
    .done       (done),
    .load_data  (load_data),
    .addr_err   (addr_err),
    .bus_err    (bus_err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected {be, wdata} built lane by lane from which sd bytes land in which lanes.
  function automatic logic [35:0] model_store(mem_op_t o, logic [1:0] k, logic [31:0] sd);
    logic [3:0]  be;
    logic [31:0] wd;
    int kk;
    kk = int'(k);
    be = 4'b0000;
    wd = 32'h0;
    for (int j = 0; j < 4; j++) begin
      case (o)
        SB: begin wd[8*j +: 8] = sd[7:0]; be[j] = (j == kk); end
        SH: begin wd[8*j +: 8] = sd[8*(j%2) +: 8]; be[j] = (j/2 == kk/2); end
        SW: begin wd[8*j +: 8] = sd[8*j +: 8]; be[j] = 1'b1; end
        SWL: if (j <= kk) begin wd[8*j +: 8] = sd[8*(3-kk+j) +: 8]; be[j] = 1'b1; end
        SWR: if (j >= kk) begin wd[8*j +: 8] = sd[8*(j-kk) +: 8]; be[j] = 1'b1; end
        default: ;
      endcase
    end
    return {be, wd};
  endfunction

  function automatic logic [31:0] model_load(mem_op_t o, logic [1:0] k, logic [31:0] rd,
                                             logic [31:0] rt);
    logic [31:0] res;
    logic [7:0]  b;
    logic [15:0] h;
    int kk;
    kk  = int'(k);
    b   = rd[8*kk +: 8];
    h   = rd[16*(kk/2) +: 16];
    res = rt;
    case (o)
      LB:  res = 32'($signed(b));
      LBU: res = 32'(b);
      LH:  res = 32'($signed(h));
      LHU: res = 32'(h);
      LW:  res = rd;
      LWL: for (int j = 0; j < 4; j++) if (j >= 3 - kk) res[8*j +: 8] = rd[8*(j-3+kk) +: 8];
      LWR: for (int j = 0; j < 4; j++) if (j <= 3 - kk) res[8*j +: 8] = rd[8*(j+kk) +: 8];
      default: res = 32'h0;
    endcase
    return res;
  endfunction

  function automatic logic model_mis(mem_op_t o, logic [1:0] k);
    if (o == LH || o == LHU || o == SH) return k[0];
    if (o == LW || o == SW) return k != 2'b00;
    return 1'b0;
  endfunction

  // Issues one op; the responder holds mem_ready low for r REQ cycles and
  // mem_rvalid low for v WAIT cycles. Cycle index 0 is the IDLE cycle.
  task automatic do_op(input mem_op_t o, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rt, input logic [31:0] rd, input int r, input int v);
    int req_n, wait_n;
    req_n = 0; wait_n = 0;
    c_stall = 0; c_req = 0; c_hang = 1; c_done_idx = -1;
    c_buserr = 1'bx; c_load = 32'hx;
    @(negedge clk);
    op_valid = 1'b1; op = o; addr = a; store_data = sd; rt_old = rt;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    #1;
    if (stall) c_stall++;
    for (int i = 1; i < 40; i++) begin
      @(negedge clk);
      mem_ready = 1'b0; mem_rvalid = 1'b0;
      if (stall) c_stall++;
      if (done) begin
        c_done_idx = i; c_load = load_data; c_buserr = bus_err; c_hang = 0;
        break;
      end
      if (mem_req) begin
        c_req++;
        c_we = mem_we; c_addr = mem_addr; c_be = mem_be; c_wdata = mem_wdata;
        mem_ready = (req_n >= r);
        req_n++;
      end else if (stall) begin
        mem_rvalid = (wait_n >= v);
        mem_rdata  = rd;
        wait_n++;
      end
    end
    op_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    mem_op_t     o;
    logic [1:0]  k;
    logic [31:0] a, sd, rt, rd, exp_ld;
    logic [35:0] es;
    int          w, r, v;

    reset = 1'b0; op_valid = 1'b0; op = LB; addr = 32'h0; store_data = 32'h0;
    rt_old = 32'h0; mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 4; i++) mem_model[i] = $urandom;
    repeat (2) @(negedge clk);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_be", 32'(mem_be), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_load", load_data, 32'd0);
    chk("rst_errs", 32'({addr_err, bus_err}), 32'd0);
    reset = 1'b1;

    do_op(SW, 32'h10, 32'hDEADBEEF, 32'h0, 32'h0, 0, 0);
    chk("sw_hang", 32'(c_hang), 32'd0);
    chk("sw_addr", c_addr, 32'h10);
    chk("sw_be", 32'(c_be), 32'hF);
    chk("sw_wdata", c_wdata, 32'hDEADBEEF);
    chk("sw_we", 32'(c_we), 32'd1);
    chk("sw_done_idx", 32'(c_done_idx), 32'd2);
    chk("sw_stall_cycles", 32'(c_stall), 32'd2);

    do_op(LB, 32'h23, 32'h0, 32'h0, 32'h80FF1234, 0, 1);
    chk("lb_load", c_load, 32'hFFFFFF80);
    chk("lb_addr", c_addr, 32'h20);
    chk("lb_we", 32'(c_we), 32'd0);
    chk("lb_done_idx", 32'(c_done_idx), 32'd4);
    do_op(LBU, 32'h23, 32'h0, 32'h0, 32'h80FF1234, 0, 1);
    chk("lbu_load", c_load, 32'h00000080);

    do_op(SWL, 32'h41, 32'hAABBCCDD, 32'h0, 32'h0, 0, 0);
    chk("swl_be", 32'(c_be), 32'h3);
    chk("swl_wdata", c_wdata, 32'h0000AABB);
    do_op(SWR, 32'h41, 32'hAABBCCDD, 32'h0, 32'h0, 0, 0);
    chk("swr_be", 32'(c_be), 32'hE);
    chk("swr_wdata", c_wdata, 32'hBBCCDD00);

    do_op(LWL, 32'h1, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 0);
    chk("lwl_load", c_load, 32'h3344CCDD);
    chk("lwl_done_idx", 32'(c_done_idx), 32'd3);
    do_op(LWR, 32'h1, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 0);
    chk("lwr_load", c_load, 32'hAA112233);

    // Memory never accepts: bus error after TMO cycles in REQ.
    do_op(SW, 32'h30, 32'h12345678, 32'h0, 32'h0, 1000, 0);
    chk("tmo_buserr", 32'(c_buserr), 32'd1);
    chk("tmo_req_cycles", 32'(c_req), 32'(TMO));
    chk("tmo_done_idx", 32'(c_done_idx), 32'(TMO + 1));
    chk("tmo_load", c_load, 32'd0);
    @(negedge clk);
    chk("tmo_pulse_done", 32'(done), 32'd0);
    chk("tmo_pulse_buserr", 32'(bus_err), 32'd0);

    do_op(LWL, 32'h1, 32'h0, 32'hAABBCCDD, 32'h11223344, 0, 0);
    chk("lwl2_load", c_load, 32'h3344CCDD);

    // Reset during WAIT, then a stale rvalid after release.
    @(negedge clk);
    op_valid = 1'b1; op = LW; addr = 32'h24; rt_old = 32'h0;
    @(negedge clk);
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    chk("wait_stall", 32'(stall), 32'd1);
    chk("wait_req", 32'(mem_req), 32'd0);
    op_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'd0);
    chk("arst_addr", mem_addr, 32'd0);
    chk("arst_be", 32'(mem_be), 32'd0);
    chk("arst_load", load_data, 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk("late_rv_done", 32'(done), 32'd0);
    chk("late_rv_load", load_data, 32'd0);
    chk("late_rv_stall", 32'(stall), 32'd0);

    @(negedge clk);
    op_valid = 1'b1; op = LH; addr = 32'h3;
    #1;
    chk("lh_mis_err", 32'(addr_err), 32'd1);
    chk("lh_mis_stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("lh_mis_req", 32'(mem_req), 32'd0);
    chk("lh_mis_err_hold", 32'(addr_err), 32'd1);
    op_valid = 1'b0;

    for (int n = 0; n < 60; n++) begin
      o  = mem_op_t'($urandom_range(0, 11));
      k  = 2'($urandom_range(0, 3));
      w  = $urandom_range(0, 3);
      a  = 32'h1000 + 32'(w * 4) + 32'(k);
      sd = $urandom;
      rt = $urandom;
      if (model_mis(o, k)) begin
        @(negedge clk);
        op_valid = 1'b1; op = o; addr = a;
        #1;
        chk("rnd_mis_err", 32'(addr_err), 32'd1);
        chk("rnd_mis_stall", 32'(stall), 32'd0);
        @(negedge clk);
        chk("rnd_mis_req", 32'(mem_req), 32'd0);
        op_valid = 1'b0;
      end else if (o >= SB) begin
        r  = $urandom_range(0, 2);
        es = model_store(o, k, sd);
        do_op(o, a, sd, rt, 32'h0, r, 0);
        chk("rnd_st_hang", 32'(c_hang), 32'd0);
        chk("rnd_st_addr", c_addr, {a[31:2], 2'b00});
        chk("rnd_st_we", 32'(c_we), 32'd1);
        chk("rnd_st_be", 32'(c_be), 32'(es[35:32]));
        chk("rnd_st_wdata", c_wdata, es[31:0]);
        chk("rnd_st_done_idx", 32'(c_done_idx), 32'(r + 2));
        chk("rnd_st_buserr", 32'(c_buserr), 32'd0);
        for (int j = 0; j < 4; j++)
          if (es[32+j]) mem_model[w][8*j +: 8] = es[8*j +: 8];
      end else begin
        r      = $urandom_range(0, 1);
        v      = $urandom_range(0, 1 - r);
        rd     = mem_model[w];
        exp_ld = model_load(o, k, rd, rt);
        do_op(o, a, sd, rt, rd, r, v);
        chk("rnd_ld_hang", 32'(c_hang), 32'd0);
        chk("rnd_ld_addr", c_addr, {a[31:2], 2'b00});
        chk("rnd_ld_we", 32'(c_we), 32'd0);
        chk("rnd_ld_data", c_load, exp_ld);
        chk("rnd_ld_done_idx", 32'(c_done_idx), 32'(r + v + 3));
        chk("rnd_ld_buserr", 32'(c_buserr), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
